ctrl_pipe_decoder: RTL
======================

# ctrl_pipe_decoder

- Parametrised main control decoder for the RV32I pipeline with CSR support.
- Decodes the fetched instruction into a fully specified control bundle, with no latched outputs.
- Carries the bundle through STAGES registered pipeline stages, with stall, flush and valid tracking.
- Flags in-flight CSR writes and illegal instructions for the hazard and trap logic.
- Sits between fetch and the execute / memory-writeback stage registers, and supersedes the fixed two-stage controller.

## Interface

Parameters:
- STAGES, 2, number of registered stages after decode; legal range 1–4.
- CW, 11, control bundle width; fixed and not to be overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- instr  in  32  instruction in the decode stage.
- instr_valid  in  1  instr is a real instruction; 0 forces an all-zero bundle.
- stall  in  1  hold all pipeline stages.
- flush  in  1  replace the stage-1 capture with a bubble.
- ctrl_d  out  CW  combinational decode bundle.
- ctrl_pipe  out  STAGES*CW  registered bundles; stage k occupies bits [k*CW-1:(k-1)*CW], k=1..STAGES.
- valid_pipe  out  STAGES  valid bit per stage; bit k-1 belongs to stage k.
- csr_busy  out  1  some valid stage holds csr_wr=1.
- illegal_trap  out  1  the last stage is valid and its illegal bit is set.

## Operation

Bundle bit order, LSB first:
- alu_en[0], reg_wr[1], sel_a[2], sel_b[3], wb_sel[5:4], mem_cs[6], mem_wr[7], csr_rd[8], csr_wr[9], illegal[10].

Decode rules:
- Field names: opcode=instr[6:0], rd=instr[11:7], funct3=instr[14:12], rs1=instr[19:15].
- Every bit not listed for an opcode is 0.

Decode table:
- 0110011 (R): alu_en, reg_wr.
- 0010011 (I-ALU): alu_en, reg_wr, sel_b.
- 0000011 (load): alu_en, reg_wr, sel_b, mem_cs, wb_sel=01.
- 0100011 (store): alu_en, sel_b, mem_cs, mem_wr.
- 1100011 (branch): alu_en, sel_a, sel_b. reg_wr=0.
- 1101111 (jal): alu_en, reg_wr, sel_a, sel_b, wb_sel=10.
- 1100111 (jalr): alu_en, reg_wr, sel_b, wb_sel=10.
- 0010111 (auipc): alu_en, reg_wr, sel_a, sel_b.
- 0110111 (lui): alu_en, reg_wr, sel_b.
- 1110011 (system), funct3 in {001,010,011,101,110,111}:
  - alu_en=1, sel_b=1, wb_sel=11.
  - reg_wr = csr_rd = (rd≠0).
  - csr_wr = (funct3[1:0]==01) | (rs1≠0).
- 1110011 (system), funct3=000: all zero (ecall/ebreak/mret are handled by trap logic).
- 1110011 (system), funct3=100: illegal=1 only.
- Any other opcode: illegal=1 only.
- instr_valid=0: bundle all zero and illegal=0.

Pipeline behaviour:
- Stage 1 captures ctrl_d and valid=instr_valid.
- Stage k>1 captures stage k-1 (bundle and valid).
- stall=1: every stage holds its contents.
- flush=1: stage 1 loads an all-zero bundle with valid=0. flush has priority over stall for stage 1.
- flush with stall: stage 1 is cleared, stages 2..STAGES hold.
- flush without stall: stages 2..STAGES advance normally.

Status outputs:
- csr_busy = OR over k of (valid_pipe[k-1] & csr_wr of stage k). Combinational from the registers.
- illegal_trap = valid_pipe[STAGES-1] & illegal of stage STAGES. Combinational from the registers.
- A held illegal instruction keeps illegal_trap high while stalled.

## Timing

- reset: on the next clk edge all ctrl_pipe and valid_pipe bits become 0. csr_busy and illegal_trap are therefore 0.
- reset overrides stall and flush. Reset asserted mid-operation discards every in-flight bundle.
- ctrl_d responds to instr and instr_valid in zero cycles; it is not gated by reset.
- Latency: an instruction decoded in cycle n appears at stage k at cycle n+k, absent stalls. Each stall cycle adds one cycle.
- A bubble (valid=0) propagates exactly like an instruction; its bundle stays all zero at every stage.
- STAGES=1: stage 1 is also the last stage. illegal_trap is then driven from stage 1, and flush can cancel a trap before it is reported.
- No combinational path from stall or flush to any output.

## Test plan

- **Full decode sweep:** apply each opcode above with instr_valid=1 plus opcode 1111111.
  - Check ctrl_d against the table.
  - Example: lw x5,0(x1) -> 0x05B (alu_en, reg_wr, sel_b, mem_cs, wb_sel=01).
  - 1111111 -> 0x400.
- **CSR field rules:**
  - csrrs x0,mstatus,x0 -> csr_rd=0, csr_wr=0, reg_wr=0.
  - csrrw x3,mtvec,x0 -> csr_wr=1, csr_rd=1, reg_wr=1.
  - csrrci x4,mie,0 -> csr_wr=0, csr_rd=1.
  - funct3=100 -> illegal.
- **Latency, STAGES=2:** issue add, sw, csrrw back-to-back.
  - Each appears at stage 1 one cycle later and at stage 2 two cycles later.
  - csr_busy is high for exactly 2 cycles.
- **Stall/flush interaction:** with lw at stage 1, assert stall and flush together for one cycle.
  - Stage 1 becomes bubble (valid=0, bundle 0).
  - Stage 2 holds its prior content.
  - Next cycle the bubble reaches stage 2.
- **Illegal trap, STAGES=3:** issue 0xFFFFFFFF with valid=1.
  - illegal_trap rises exactly 3 cycles later.
  - illegal_trap stays high through 2 stall cycles, then clears when the next cycle advances.
- **Reset mid-flight:** fill all stages with valid instructions, then assert reset together with stall.
  - Next edge: all valid_pipe bits and bundles are 0.
  - csr_busy and illegal_trap are 0.

Source files
------------

// File: rtl/ctrl_pipe_decoder_if.sv
// Decode-stage bundle: fetch/hazard side drives instruction and pipeline control,
// the decoder returns the control bundles and the hazard/trap status flags.
interface ctrl_pipe_decoder_if #(
   parameter int STAGES = 2,
   parameter int CW     = 11
);
   logic [31:0]          instr;
   logic                 instr_valid;
   logic                 stall;
   logic                 flush;
   logic [CW-1:0]        ctrl_d;
   logic [STAGES*CW-1:0] ctrl_pipe;
   logic [STAGES-1:0]    valid_pipe;
   logic                 csr_busy;
   logic                 illegal_trap;

   modport master (
      output instr, instr_valid, stall, flush,
      input  ctrl_d, ctrl_pipe, valid_pipe, csr_busy, illegal_trap
   );

   modport slave (
      input  instr, instr_valid, stall, flush,
      output ctrl_d, ctrl_pipe, valid_pipe, csr_busy, illegal_trap
   );
endinterface

// File: rtl/ctrl_pipe_decoder.sv
// RV32I main control decoder with CSR fields, followed by a STAGES-deep control
// pipeline tracking valid, stall and flush for the hazard and trap logic.
module ctrl_pipe_decoder #(
   parameter int STAGES = 2,
   parameter int CW     = 11
) (
   input  logic               clk,
   input  logic               reset,
   ctrl_pipe_decoder_if.slave bus
);

   // Bundle layout, LSB first: alu_en, reg_wr, sel_a, sel_b, wb_sel[1:0],
   // mem_cs, mem_wr, csr_rd, csr_wr, illegal.
   localparam logic [10:0] B_ALU    = 11'h001;
   localparam logic [10:0] B_REG    = 11'h002;
   localparam logic [10:0] B_SELA   = 11'h004;
   localparam logic [10:0] B_SELB   = 11'h008;
   localparam logic [10:0] B_WB_MEM = 11'h010;
   localparam logic [10:0] B_WB_PC  = 11'h020;
   localparam logic [10:0] B_WB_CSR = 11'h030;
   localparam logic [10:0] B_MEMCS  = 11'h040;
   localparam logic [10:0] B_MEMWR  = 11'h080;
   localparam logic [10:0] B_CSRRD  = 11'h100;
   localparam logic [10:0] B_CSRWR  = 11'h200;
   localparam logic [10:0] B_ILL    = 11'h400;
   localparam int          BIT_CSRWR = 9;
   localparam int          BIT_ILL   = 10;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [6:0]                   opcode_s;
   logic [4:0]                   rd_s;
   logic [2:0]                   funct3_s;
   logic [4:0]                   rs1_s;
   logic                         instr_hi_unused_s;
   logic                         csr_rd_s;
   logic                         csr_wr_s;
   logic [CW-1:0]                csr_bits_s;
   logic [CW-1:0]                dec_s;
   logic                         csr_busy_s;
   logic [STAGES-1:0][CW-1:0]    stage_r;
   logic [STAGES-1:0]            valid_r;

   assign opcode_s          = bus.instr[6:0];
   assign rd_s              = bus.instr[11:7];
   assign funct3_s          = bus.instr[14:12];
   assign rs1_s             = bus.instr[19:15];
   assign instr_hi_unused_s = ^bus.instr[31:20];

   // csrrw/csrrwi always write; set/clear forms write only with a non-zero source.
   assign csr_rd_s   = (rd_s != 5'd0);
   assign csr_wr_s   = (funct3_s[1:0] == 2'b01) | (rs1_s != 5'd0);
   assign csr_bits_s = (csr_rd_s ? (B_REG | B_CSRRD) : 11'h000)
                     | (csr_wr_s ? B_CSRWR : 11'h000);

   // Instruction decode; unrecognised opcodes yield an illegal-only bundle.
   always_comb begin
      dec_s = '0;
      if (bus.instr_valid) begin
         case (opcode_s)
            OP_R:      dec_s = B_ALU | B_REG;
            OP_IALU:   dec_s = B_ALU | B_REG | B_SELB;
            OP_LOAD:   dec_s = B_ALU | B_REG | B_SELB | B_MEMCS | B_WB_MEM;
            OP_STORE:  dec_s = B_ALU | B_SELB | B_MEMCS | B_MEMWR;
            OP_BRANCH: dec_s = B_ALU | B_SELA | B_SELB;
            OP_JAL:    dec_s = B_ALU | B_REG | B_SELA | B_SELB | B_WB_PC;
            OP_JALR:   dec_s = B_ALU | B_REG | B_SELB | B_WB_PC;
            OP_AUIPC:  dec_s = B_ALU | B_REG | B_SELA | B_SELB;
            OP_LUI:    dec_s = B_ALU | B_REG | B_SELB;
            OP_SYSTEM: begin
               case (funct3_s)
                  3'b000:  dec_s = '0;
                  3'b100:  dec_s = B_ILL;
                  default: dec_s = B_ALU | B_SELB | B_WB_CSR | csr_bits_s;
               endcase
            end
            default:   dec_s = B_ILL;
         endcase
      end else begin
         dec_s = '0;
      end
   end

   // Stage registers: flush beats stall on stage 1 only; deeper stages follow stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_r <= '0;
         valid_r <= '0;
      end else begin
         if (bus.flush) begin
            stage_r[0] <= '0;
            valid_r[0] <= 1'b0;
         end else if (!bus.stall) begin
            stage_r[0] <= dec_s;
            valid_r[0] <= bus.instr_valid;
         end else begin
            stage_r[0] <= stage_r[0];
            valid_r[0] <= valid_r[0];
         end
         for (int k = 1; k < STAGES; k++) begin
            if (!bus.stall) begin
               stage_r[k] <= stage_r[k-1];
               valid_r[k] <= valid_r[k-1];
            end else begin
               stage_r[k] <= stage_r[k];
               valid_r[k] <= valid_r[k];
            end
         end
      end
   end

   // Any valid in-flight CSR write blocks CSR reads in the hazard unit.
   always_comb begin
      csr_busy_s = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         csr_busy_s = csr_busy_s | (valid_r[k] & stage_r[k][BIT_CSRWR]);
      end
   end

   assign bus.ctrl_d       = dec_s;
   assign bus.ctrl_pipe    = stage_r;
   assign bus.valid_pipe   = valid_r;
   assign bus.csr_busy     = csr_busy_s;
   assign bus.illegal_trap = valid_r[STAGES-1] & stage_r[STAGES-1][BIT_ILL];

endmodule
